// File: rtl/bsg_mux_pkg.sv
// Shared types and helpers for the per-bit selector pipeline.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package bsg_mux_pkg;

    // Occupancy of the 2-entry output buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    // A per-bit select addresses no input when it is at or above the input count
    function automatic logic sel_out_of_range(input int unsigned sel, input int unsigned els);
        return (sel >= els);
    endfunction

endpackage

// File: rtl/bsg_mux_bitwise.sv
// Per-bit N:1 mux: output bit b takes bit b of input sel[b]; out-of-range selects give 0.
// Latency: purely combinational.
// Backpressure: none, no state.
module bsg_mux_bitwise
    import bsg_mux_pkg::*;
#(
    parameter int width_p   = 64,
    parameter int els_p     = 3,
    parameter int lg_els_lp = $clog2(els_p)
) (
    input  logic [els_p*width_p-1:0]     data_i,
    input  logic [width_p*lg_els_lp-1:0] sel_i,
    output logic [width_p-1:0]           data_o
);

    // Each bit scans the inputs for a matching select; no match leaves the bit at 0
    always_comb begin
        data_o = '0;
        for (int b = 0; b < width_p; b++) begin
            for (int k = 0; k < els_p; k++) begin
                if (sel_i[b*lg_els_lp +: lg_els_lp] == lg_els_lp'(k)) begin
                    data_o[b] = data_i[k*width_p + b];
                end
            end
        end
    end

endmodule

// File: rtl/bsg_mux_bitwise_pipe.sv
// Per-bit N:1 selector feeding a 2-entry registered FIFO with valid/ready in, valid/yumi out.
// Latency: 1 cycle from enqueue to v_o; data_o/err_o come from the head register.
// Backpressure: ready_o drops when both entries are held; it never depends on yumi_i.
// Optional out-of-range select flag on err_o when BSG_MUX_BITWISE_PIPE_ERR_EN is defined.
module bsg_mux_bitwise_pipe
    import bsg_mux_pkg::*;
#(
    parameter int width_p   = 64,
    parameter int els_p     = 3,
    parameter int lg_els_lp = $clog2(els_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  logic [els_p*width_p-1:0]     data_i,
    input  logic [width_p*lg_els_lp-1:0] sel_i,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    output logic                         err_o,
    input  logic                         yumi_i
);

    buf_state_e         state_q, state_d;
    logic               wr_ptr_q, rd_ptr_q;
    logic [width_p-1:0] mem_q [2];
    logic [width_p-1:0] mux_dat;
    logic               enq, deq;

    bsg_mux_bitwise #(
        .width_p   (width_p),
        .els_p     (els_p),
        .lg_els_lp (lg_els_lp)
    ) u_mux (
        .data_i (data_i),
        .sel_i  (sel_i),
        .data_o (mux_dat)
    );

    // Illegal handshakes are masked so they cannot disturb the buffer
    assign enq = v_i & ready_o;
    assign deq = yumi_i & v_o;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_EMPTY;
        else         state_q <= state_d;
    end

    // Occupancy transitions; enq and deq together in ONE keeps ONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (enq)         state_d = ST_ONE;
            ST_ONE:   if (enq && !deq) state_d = ST_FULL;
                      else if (!enq && deq) state_d = ST_EMPTY;
            ST_FULL:  if (deq)         state_d = ST_ONE;
            default:                   state_d = ST_EMPTY;
        endcase
    end

    // Handshake outputs decoded from occupancy only
    always_comb begin
        ready_o = (state_q != ST_FULL) & ~reset_i;
        v_o     = (state_q != ST_EMPTY);
    end

    // Storage and pointers; reset clears entries so the head reads 0
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (enq) begin
                mem_q[wr_ptr_q] <= mux_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (deq) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign data_o = mem_q[rd_ptr_q];

`ifdef BSG_MUX_BITWISE_PIPE_ERR_EN
    logic err_d;
    logic err_q [2];

    // A beat is flagged if any of its per-bit selects addresses no input
    always_comb begin
        err_d = 1'b0;
        for (int b = 0; b < width_p; b++) begin
            err_d = err_d | sel_out_of_range(int'(sel_i[b*lg_els_lp +: lg_els_lp]), els_p);
        end
    end

    // Flag storage tracks the data entries one-for-one
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q[0] <= 1'b0;
            err_q[1] <= 1'b0;
        end else if (enq) begin
            err_q[wr_ptr_q] <= err_d;
        end
    end

    assign err_o = err_q[rd_ptr_q];
`else
    assign err_o = 1'b0;
`endif

    a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
        else $error("yumi_i asserted while v_o=0");
    a_no_v_when_not_ready: assert property (@(posedge clk_i) disable iff (reset_i) !(v_i && !ready_o))
        else $error("v_i asserted while ready_o=0");

endmodule
